// File: rtl/audio_echo_fx.sv
// Mono streaming echo stage. Each accepted sample is mixed with a delayed copy
// held in an on-chip circular buffer. The buffer is rewritten with the input
// plus a scaled copy of the delayed signal, which produces decaying repeats.
// Valid/ready handshake on both stream sides; one sample in flight at a time.
module audio_echo_fx #(
   parameter int DATA_W = 24,
   parameter int ADDR_W = 14
) (
   input  logic              clk_clk,
   input  logic              reset_reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   input  logic [ADDR_W-1:0] delay_samples,
   input  logic [7:0]        fb_gain,
   input  logic [7:0]        mix_gain,
   input  logic              bypass
);

   localparam int DEPTH  = 1 << ADDR_W;
   localparam int PROD_W = DATA_W + 9;
   localparam int SUM_W  = DATA_W + 1;

   typedef enum logic [2:0] {
      S_CLEAR,
      S_IDLE,
      S_READ,
      S_CALC,
      S_OUT
   } state_t;

   state_t state, state_next;

   // Delay line and its access signals
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] clr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] d_eff;

   // Per-sample captured operands; settings changes only affect the next sample
   logic [DATA_W-1:0] x_q;
   logic [7:0]        fb_q;
   logic [7:0]        mix_q;
   logic              byp_q;

   logic signed [PROD_W-1:0] d_ext, mix_ext, fb_ext;
   logic signed [PROD_W-1:0] wet_prod, fb_prod;
   logic signed [SUM_W-1:0]  wet, fbv;
   logic [SUM_W-1:0]         out_sum, fb_sum;

   logic accept;

   // Clamp a DATA_W+1 bit sum back into the signed DATA_W range
   function automatic logic [DATA_W-1:0] sat(input logic [SUM_W-1:0] v);
      if (v[SUM_W-1] != v[SUM_W-2]) begin
         if (v[SUM_W-1]) return {1'b1, {(DATA_W-1){1'b0}}};
         else            return {1'b0, {(DATA_W-1){1'b1}}};
      end
      return v[DATA_W-1:0];
   endfunction

   assign accept = in_valid && in_ready;

   // A delay of zero would read the slot about to be written; treat it as one
   assign d_eff = (delay_samples == '0) ? ADDR_W'(1) : delay_samples;

   // Gains are unsigned Q0.8, so they are zero-extended before the signed multiply
   assign d_ext    = {{9{rd_data[DATA_W-1]}}, rd_data};
   assign mix_ext  = {{(PROD_W-8){1'b0}}, mix_q};
   assign fb_ext   = {{(PROD_W-8){1'b0}}, fb_q};
   assign wet_prod = d_ext * mix_ext;
   assign fb_prod  = d_ext * fb_ext;
   assign wet      = SUM_W'(wet_prod >>> 8);
   assign fbv      = SUM_W'(fb_prod >>> 8);
   assign out_sum  = {x_q[DATA_W-1], x_q} + wet;
   assign fb_sum   = {x_q[DATA_W-1], x_q} + fbv;

   // Next state and stream handshake outputs
   // NOTE: every signal written here gets a default first, otherwise a path that skips it infers a latch.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         S_CLEAR: if (clr_addr == '1) state_next = S_IDLE;
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = S_READ;
         end
         S_READ:  state_next = S_CALC;
         S_CALC:  state_next = S_OUT;
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_next = S_IDLE;
         end
         default: state_next = S_CLEAR;
      endcase
   end

   // State register, pointers and the output sample
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state    <= S_CLEAR;
         clr_addr <= '0;
         wr_ptr   <= '0;
         out_data <= '0;
      end else begin
         state <= state_next;
         if (state == S_CLEAR) clr_addr <= clr_addr + ADDR_W'(1);
         if (state == S_CALC) begin
            out_data <= byp_q ? x_q : sat(out_sum);
            wr_ptr   <= wr_ptr + ADDR_W'(1);
         end
      end
   end

   // Capture the sample, its settings and the delayed read address on accept
   always_ff @(posedge clk_clk) begin
      if (!reset_reset && accept) begin
         x_q     <= in_data;
         fb_q    <= fb_gain;
         mix_q   <= mix_gain;
         byp_q   <= bypass;
         rd_addr <= wr_ptr - d_eff;
      end
   end

   // Single write port shared by the clear sweep and the feedback write
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_ptr;
      mem_wdata = sat(fb_sum);
      if (state == S_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_addr;
         mem_wdata = '0;
      end else if (state == S_CALC) begin
         mem_we = 1'b1;
      end
   end

   // Buffer RAM with registered read; bypass does not suppress the write
   // NOTE: the RAM has no reset term so it maps to block memory; the CLEAR sweep zeroes it instead.
   always_ff @(posedge clk_clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      rd_data <= mem[rd_addr];
   end

endmodule
